// File: rtl/audio_fft_pkg.sv
// Shared widths, FSM state, pipeline tag and the power saturation helper for
// the FFT power-spectrum stage.
package audio_fft_pkg;

  localparam int IN_W      = 29;
  localparam int OUT_W     = 16;
  localparam int PTS_W     = 11;
  localparam int SHIFT_DEF = 40;
  localparam int SUM_W     = 2 * IN_W + 1;

  localparam logic [OUT_W-1:0] SAT_MAX = '1;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [PTS_W-1:0] bin;
    logic             sop;
    logic             eop;
  } tag_t;

  // Scale the raw power down and clamp anything that no longer fits OUT_W.
  function automatic logic [OUT_W-1:0] sat_shift(input logic [SUM_W-1:0] sum,
                                                 input int unsigned      sh);
    logic [SUM_W-1:0] s;
    s = sum >> sh;
    if (s > SUM_W'(SAT_MAX)) return SAT_MAX;
    return s[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/audio_fft_power_sq.sv
// Two-stage squarer/adder: registered re^2 and im^2, then their registered sum.
module audio_fft_power_sq
  import audio_fft_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en_i,
  input  logic signed [IN_W-1:0]  re_i,
  input  logic signed [IN_W-1:0]  im_i,
  output logic        [SUM_W-1:0] sum_o
);

  logic signed [2*IN_W-1:0] re_x, im_x;
  logic        [2*IN_W-1:0] re_sq_d, im_sq_d, re_sq_q, im_sq_q;
  logic        [SUM_W-1:0]  sum_d, sum_q;

  // Squares are never negative and the largest, (-2^(IN_W-1))^2, still fits.
  assign re_x    = {{IN_W{re_i[IN_W-1]}}, re_i};
  assign im_x    = {{IN_W{im_i[IN_W-1]}}, im_i};
  assign re_sq_d = re_x * re_x;
  assign im_sq_d = im_x * im_x;
  assign sum_d   = {1'b0, re_sq_q} + {1'b0, im_sq_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      re_sq_q <= '0;
      im_sq_q <= '0;
      sum_q   <= '0;
    end else if (en_i) begin
      re_sq_q <= re_sq_d;
      im_sq_q <= im_sq_d;
      sum_q   <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/audio_fft_power.sv
// Power spectrum stage: frames FFT beats, keeps bins 0..N/2-1 and emits a
// saturated, scaled re^2+im^2 per bin with ready/valid backpressure.
module audio_fft_power
  import audio_fft_pkg::*;
#(
  parameter int unsigned SHIFT = SHIFT_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic        [1:0]       in_error,
  input  logic                    in_sop,
  input  logic                    in_eop,
  input  logic signed [IN_W-1:0]  in_real,
  input  logic signed [IN_W-1:0]  in_imag,
  input  logic        [PTS_W-1:0] in_fftpts,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic        [OUT_W-1:0] out_power,
  output logic        [PTS_W-1:0] out_bin,
  output logic                    frame_err
);

  state_e             state_q, state_d;
  logic [PTS_W-1:0]   cnt_q, cnt_d, n_q, n_d;
  logic               ferr_q, ferr_d;
  logic               accept, in_frame, last_bin;
  tag_t               tag_d, tag1_q, tag2_q, out_tag_q;
  logic [OUT_W-1:0]   out_power_q;
  logic [SUM_W-1:0]   sq_sum;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      ferr_q  <= ferr_d;
    end
  end

  // cnt_q is the bin index the next in-frame beat will carry.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    ferr_d   = 1'b0;
    in_frame = 1'b0;
    last_bin = 1'b0;
    tag_d    = '{valid: 1'b0, bin: cnt_q, sop: 1'b0, eop: 1'b0};
    if (accept) begin
      ferr_d = (in_error != 2'b00);
      if (in_sop) begin
        ferr_d    = ferr_d | (state_q == IN_FRAME);
        n_d       = in_fftpts;
        cnt_d     = '0;
        tag_d.bin = '0;
        if (in_fftpts < PTS_W'(2)) begin
          ferr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          in_frame = 1'b1;
        end
      end else if (state_q == IN_FRAME) begin
        in_frame = 1'b1;
      end else begin
        ferr_d = 1'b1;
      end
      if (in_frame) begin
        last_bin    = (tag_d.bin == n_d - PTS_W'(1));
        cnt_d       = tag_d.bin + PTS_W'(1);
        tag_d.valid = (tag_d.bin < (n_d >> 1));
        tag_d.sop   = (tag_d.bin == '0);
        tag_d.eop   = (tag_d.bin == (n_d >> 1) - PTS_W'(1));
        if (in_eop || last_bin) begin
          state_d = IDLE;
          if (!(in_eop && last_bin)) ferr_d = 1'b1;
        end else begin
          state_d = IN_FRAME;
        end
      end
    end
  end

  always_comb begin
    in_ready = out_ready | ~out_tag_q.valid;
  end

  audio_fft_power_sq u_sq (
    .clk    (clk),
    .reset_n(reset_n),
    .en_i   (in_ready),
    .re_i   (in_real),
    .im_i   (in_imag),
    .sum_o  (sq_sum)
  );

  // Tags travel alongside the squarer so each power keeps its own frame's bin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag1_q      <= '0;
      tag2_q      <= '0;
      out_tag_q   <= '0;
      out_power_q <= '0;
    end else if (in_ready) begin
      tag1_q      <= tag_d;
      tag2_q      <= tag1_q;
      out_tag_q   <= tag2_q;
      out_power_q <= sat_shift(sq_sum, SHIFT);
    end
  end

  assign out_valid = out_tag_q.valid;
  assign out_sop   = out_tag_q.sop;
  assign out_eop   = out_tag_q.eop;
  assign out_bin   = out_tag_q.bin;
  assign out_power = out_power_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_audio_fft_power.sv
// Randomized bench for audio_fft_power against a frame-level reference model.
module tb_audio_fft_power;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_sop = 1'b0;
  logic               in_eop = 1'b0;
  logic        [1:0]  in_error = 2'b00;
  logic signed [28:0] in_real = '0;
  logic signed [28:0] in_imag = '0;
  logic        [10:0] in_fftpts = '0;
  logic               out_ready = 1'b1;
  logic               in_ready, out_valid, out_sop, out_eop, frame_err;
  logic        [15:0] out_power;
  logic        [10:0] out_bin;

  always #5 clk = ~clk;

  audio_fft_power dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_error (in_error),
    .in_sop   (in_sop),
    .in_eop   (in_eop),
    .in_real  (in_real),
    .in_imag  (in_imag),
    .in_fftpts(in_fftpts),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sop  (out_sop),
    .out_eop  (out_eop),
    .out_power(out_power),
    .out_bin  (out_bin),
    .frame_err(frame_err)
  );

  typedef struct {
    longint power;
    int     bin;
    bit     sop;
    bit     eop;
  } exp_t;

  exp_t   exp_q[$];
  int     chk_cnt = 0;
  int     pass_cnt = 0;
  int     m_pos = -1;
  int     m_n = 0;
  int     cyc = 0;
  int     out_cnt = 0;
  bit     err_exp, acc, xfer, bp_mode, rnd_ready, prev_stall;
  longint sv_word;

  task automatic check(input string tag, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic longint ref_power(input int re, input int im);
    longint s;
    s = (longint'(re) * re + longint'(im) * im) >> 40;
    return (s > 65535) ? 65535 : s;
  endfunction

  // Frame rules applied to one accepted beat; m_pos = -1 means between frames.
  task automatic model_accept(input bit sop, input bit eop, input int re,
                              input int im, input int pts, input int err);
    bit e;
    int bin;
    exp_t x;
    e = (err != 0);
    if (sop) begin
      if (m_pos >= 0) e = 1;
      m_n = pts;
      if (pts < 2) begin
        m_pos = -1;
        err_exp = 1;
        return;
      end
      bin = 0;
    end else if (m_pos < 0) begin
      err_exp = 1;
      return;
    end else begin
      bin = m_pos;
    end
    if (bin < m_n / 2) begin
      x.power = ref_power(re, im);
      x.bin   = bin;
      x.sop   = (bin == 0);
      x.eop   = (bin == m_n / 2 - 1);
      exp_q.push_back(x);
    end
    if (eop || bin == m_n - 1) begin
      if (!(eop && bin == m_n - 1)) e = 1;
      m_pos = -1;
    end else begin
      m_pos = bin + 1;
    end
    err_exp = e;
  endtask

  // One clock: called just after a negedge with inputs driven, returns at the next negedge.
  task automatic tick();
    exp_t x;
    cyc++;
    if (bp_mode) out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    else if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    else out_ready = 1'b1;
    #1;
    err_exp = 0;
    acc  = in_valid && in_ready;
    xfer = out_valid && out_ready;
    check("in_ready", longint'(in_ready), longint'(!(out_valid && !out_ready)));
    if (prev_stall)
      check("stall_hold", longint'({out_valid, out_sop, out_eop, out_bin, out_power}), sv_word);
    prev_stall = out_valid && !out_ready;
    sv_word = longint'({out_valid, out_sop, out_eop, out_bin, out_power});
    if (xfer) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_out", longint'(out_bin), -1);
      end else begin
        x = exp_q.pop_front();
        $display("out bin=%0d power=%0d sop=%0d eop=%0d", out_bin, out_power, out_sop, out_eop);
        check("power", longint'(out_power), x.power);
        check("bin", longint'(out_bin), longint'(x.bin));
        check("sop", longint'(out_sop), longint'(x.sop));
        check("eop", longint'(out_eop), longint'(x.eop));
      end
    end
    if (acc) model_accept(in_sop, in_eop, int'(in_real), int'(in_imag), int'(in_fftpts), int'(in_error));
    @(posedge clk);
    #1;
    check("frame_err", longint'(frame_err), longint'(err_exp));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_beat(input bit sop, input bit eop, input int re, input int im,
                           input int pts, input int err);
    bit done;
    in_sop    = sop;
    in_eop    = eop;
    in_real   = 29'(re);
    in_imag   = 29'(im);
    in_fftpts = 11'(pts);
    in_error  = 2'(err);
    in_valid  = 1'b1;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      done = acc;
    end
    if (!done) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_error = 2'b00;
  endtask

  function automatic int rnd_sample();
    int r;
    r = $urandom;
    return r >>> (3 + $urandom_range(0, 14));
  endfunction

  task automatic send_frame(input int beats, input int pts, input int eop_at,
                            input int err_at, input int sop_at, input bit gaps);
    for (int b = 0; b < beats; b++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle(1);
      send_beat(b == 0 || b == sop_at, b == eop_at, rnd_sample(), rnd_sample(), pts,
                (b == err_at) ? 1 : 0);
    end
  endtask

  initial begin
    int n, base, eop_at, err_at;
    #3;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_sop_eop", longint'({out_sop, out_eop}), 0);
    check("rst_power", longint'(out_power), 0);
    check("rst_bin", longint'(out_bin), 0);
    check("rst_frame_err", longint'(frame_err), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    // Nominal N=8 frame with latency probe on bin 0.
    send_beat(1, 0, 3 << 20, 4 << 20, 8, 0);
    #1 check("latency_c1", longint'(out_valid), 0);
    tick();
    check("latency_c2", longint'(out_valid), 0);
    tick();
    check("latency_c3", longint'(out_valid), 1);
    for (int b = 1; b < 8; b++) send_beat(0, b == 7, 0, 0, 8, 0);
    idle(6);

    // Saturation and the smallest non-zero scaled power.
    send_beat(1, 0, -(1 << 28), -(1 << 28), 4, 0);
    send_beat(0, 0, 1 << 20, 0, 4, 0);
    send_beat(0, 0, 0, 0, 4, 0);
    send_beat(0, 1, 0, 0, 4, 0);
    send_beat(1, 1, 5 << 20, 0, 2, 0);
    idle(6);

    // Backpressure with out_ready pattern 1,0,0,1.
    bp_mode = 1;
    base = out_cnt;
    send_frame(16, 16, 15, -1, -1, 0);
    idle(16);
    bp_mode = 0;
    check("bp_count", longint'(out_cnt - base), 8);

    // Framing faults: early eop, beat outside a frame, restart mid-frame,
    // N below 2, missing eop, and a non-zero error code.
    send_frame(6, 8, 5, -1, -1, 0);
    send_beat(0, 0, 7 << 20, 0, 8, 0);
    send_frame(18, 16, 17, -1, 2, 0);
    send_beat(1, 1, 1 << 20, 0, 1, 0);
    send_frame(4, 4, -1, -1, -1, 0);
    send_frame(8, 8, 7, 1, -1, 0);
    idle(6);

    // Asynchronous reset with beats in flight.
    send_frame(3, 8, -1, -1, -1, 0);
    in_sop = 1'b0; in_eop = 1'b0; in_valid = 1'b1;
    #2 reset_n = 1'b0;
    #1 check("rst_async_valid", longint'(out_valid), 0);
    check("rst_async_power", longint'(out_power), 0);
    in_valid = 1'b0;
    exp_q.delete();
    m_pos = -1;
    m_n = 0;
    prev_stall = 0;
    idle(2);
    reset_n = 1'b1;
    base = out_cnt;
    send_frame(4, 4, 3, -1, -1, 0);
    idle(8);
    check("post_rst_count", longint'(out_cnt - base), 2);

    // Randomized frames, gaps, backpressure and occasional faults.
    rnd_ready = 1;
    for (int f = 0; f < 14; f++) begin
      n = 1 << $urandom_range(1, 5);
      eop_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, n - 1)) : n - 1;
      err_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      send_frame(eop_at + 1, n, eop_at, err_at, -1, 1);
      if ($urandom_range(0, 4) == 0) send_beat(0, 0, rnd_sample(), 0, n, 0);
    end
    idle(20);
    rnd_ready = 0;
    idle(4);
    check("drain_empty", longint'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
